// File: rtl/ysyx_040066_pkg.sv
// Shared types for the ysyx_040066 load/store unit: FSM states, access sizes,
// error codes and the store lane helpers.
package ysyx_040066_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_DONE = 2'd3
    } lsu_state_e;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;
    localparam logic [1:0] SZ_D = 2'b11;

    localparam logic [1:0] ERR_NONE     = 2'b00;
    localparam logic [1:0] ERR_MISALIGN = 2'b01;
    localparam logic [1:0] ERR_BUS      = 2'b10;

    function automatic logic misaligned(input logic [1:0] size, input logic [2:0] a);
        case (size)
            SZ_H:    return a[0];
            SZ_W:    return a[1:0] != 2'b00;
            SZ_D:    return a != 3'b000;
            default: return 1'b0;
        endcase
    endfunction

    function automatic logic [7:0] store_wmask(input logic [1:0] size, input logic [2:0] a);
        case (size)
            SZ_B:    return 8'h01 << a;
            SZ_H:    return 8'h03 << {a[2:1], 1'b0};
            SZ_W:    return 8'h0f << {a[2], 2'b00};
            default: return 8'hff;
        endcase
    endfunction

    // Replicate the source across all lanes so the byte mask alone picks the target.
    function automatic logic [63:0] store_wdata(input logic [1:0] size, input logic [63:0] d);
        case (size)
            SZ_B:    return {8{d[7:0]}};
            SZ_H:    return {4{d[15:0]}};
            SZ_W:    return {2{d[31:0]}};
            default: return d;
        endcase
    endfunction

endpackage

// File: rtl/ysyx_040066_load_align.sv
// Load data alignment: selects the addressed byte/half/word from the 64-bit bus
// beat and sign- or zero-extends it to 64 bits.
module ysyx_040066_load_align
    import ysyx_040066_pkg::*;
(
    input  logic [2:0]  addr_lo,
    input  logic [2:0]  mem_op,
    input  logic [63:0] rdata,
    output logic [63:0] data
);

    logic [63:0] shifted;
    logic        sext;

    always_comb begin
        shifted = rdata >> {addr_lo, 3'b000};
        sext    = ~mem_op[2];
        case (mem_op[1:0])
            SZ_B:    data = {{56{sext & shifted[7]}},  shifted[7:0]};
            SZ_H:    data = {{48{sext & shifted[15]}}, shifted[15:0]};
            SZ_W:    data = {{32{sext & shifted[31]}}, shifted[31:0]};
            default: data = shifted;
        endcase
    end

endmodule

// File: rtl/ysyx_040066_lsu.sv
// Load/store unit: accepts one EX result at a time, performs at most one bus
// access (request/grant, then response) and presents the writeback to MEM/WB.
module ysyx_040066_lsu
    import ysyx_040066_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_in,
    output logic        in_ready,
    input  logic [63:0] addr_in,
    input  logic [63:0] wdata_in,
    input  logic [2:0]  MemOp_in,
    input  logic        MemRd_in,
    input  logic        MemWr_in,
    input  logic        RegWr_in,
    input  logic [4:0]  rd_in,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata,
    input  logic        mem_err,
    output logic        valid_out,
    output logic [63:0] result,
    output logic [4:0]  rd,
    output logic        RegWr,
    output logic [1:0]  error,
    input  logic        block_out,
    output lsu_state_e  state_dbg
);

    // Handshakes: an input transfer happens on a clock edge with valid_in & in_ready;
    // a bus request is held stable until the edge with mem_req & mem_gnt, after which
    // the next mem_rvalid completes it; the output retires on valid_out & !block_out.

    lsu_state_e  state, state_n;
    logic [63:0] addr_q, wdata_q, load_data;
    logic [2:0]  memop_q;
    logic        memwr_q, regwr_q;
    logic        is_mem, is_mis;

    assign is_mem = MemRd_in | MemWr_in;
    assign is_mis = misaligned(MemOp_in[1:0], addr_in[2:0]);

    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: if (valid_in) state_n = (is_mem && !is_mis) ? S_REQ : S_DONE;
            S_REQ:  if (mem_gnt) state_n = S_WAIT;
            S_WAIT: if (mem_rvalid) state_n = S_DONE;
            S_DONE: if (!block_out) state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_n;
    end

    assign state_dbg = state;
    assign in_ready  = (state == S_IDLE);
    assign valid_out = (state == S_DONE);
    assign mem_req   = (state == S_REQ);
    assign mem_we    = mem_req & memwr_q;
    assign mem_addr  = {addr_q[63:3], 3'b000};
    assign mem_wdata = store_wdata(memop_q[1:0], wdata_q);
    assign mem_wmask = (mem_req & memwr_q) ? store_wmask(memop_q[1:0], addr_q[2:0]) : 8'h00;

    ysyx_040066_load_align u_load_align (
        .addr_lo (addr_q[2:0]),
        .mem_op  (memop_q),
        .rdata   (mem_rdata),
        .data    (load_data)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q  <= '0;
            wdata_q <= '0;
            memop_q <= '0;
            memwr_q <= 1'b0;
            regwr_q <= 1'b0;
            result  <= '0;
            rd      <= '0;
            RegWr   <= 1'b0;
            error   <= ERR_NONE;
        end else begin
            case (state)
                S_IDLE: if (valid_in) begin
                    addr_q  <= addr_in;
                    wdata_q <= wdata_in;
                    memop_q <= MemOp_in;
                    memwr_q <= MemWr_in;
                    regwr_q <= RegWr_in & ~MemWr_in;
                    rd      <= rd_in;
                    if (!is_mem) begin
                        result <= addr_in;
                        RegWr  <= RegWr_in;
                        error  <= ERR_NONE;
                    end else if (is_mis) begin
                        result <= '0;
                        RegWr  <= 1'b0;
                        error  <= ERR_MISALIGN;
                    end
                end
                S_WAIT: if (mem_rvalid) begin
                    if (mem_err) begin
                        result <= '0;
                        RegWr  <= 1'b0;
                        error  <= ERR_BUS;
                    end else begin
                        result <= memwr_q ? 64'd0 : load_data;
                        RegWr  <= regwr_q;
                        error  <= ERR_NONE;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_040066_lsu.sv
// Directed bench for ysyx_040066_lsu: a table of single operations with a simple
// bus responder, plus hand-written reset-abort and recovery sequences.
`timescale 1ns/1ps
module tb_ysyx_040066_lsu;
    import ysyx_040066_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, in_ready;
    logic [63:0] addr_in, wdata_in;
    logic [2:0]  MemOp_in;
    logic        MemRd_in, MemWr_in, RegWr_in;
    logic [4:0]  rd_in;
    logic        mem_req, mem_we;
    logic [63:0] mem_addr, mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt, mem_rvalid, mem_err;
    logic [63:0] mem_rdata;
    logic        valid_out;
    logic [63:0] result;
    logic [4:0]  rd;
    logic        RegWr;
    logic [1:0]  error;
    logic        block_out;
    lsu_state_e  state_dbg;

    always #5 clk = ~clk;

    ysyx_040066_lsu dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
        .addr_in(addr_in), .wdata_in(wdata_in), .MemOp_in(MemOp_in),
        .MemRd_in(MemRd_in), .MemWr_in(MemWr_in), .RegWr_in(RegWr_in), .rd_in(rd_in),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_err(mem_err),
        .valid_out(valid_out), .result(result), .rd(rd), .RegWr(RegWr), .error(error),
        .block_out(block_out), .state_dbg(state_dbg)
    );

    typedef struct {
        logic [63:0] addr;
        logic [63:0] wdata;
        logic [2:0]  op;
        logic        rd_en;
        logic        wr_en;
        logic        regwr;
        logic [4:0]  rd;
        logic [63:0] rdata;
        logic        err;
        int          gnt_dly;
        int          rv_dly;
        int          blk;
        logic        exp_req;
        logic [63:0] exp_maddr;
        logic [63:0] exp_wdata;
        logic [7:0]  exp_wmask;
        logic [63:0] exp_result;
        logic [1:0]  exp_error;
        logic        exp_regwr;
    } vec_t;

    localparam int NV = 18;
    vec_t        vecs[NV];
    logic [63:0] exp_q[$];
    int          n_chk = 0;
    int          n_fail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input int i, input vec_t v);
        chk($sformatf("v%0d_mem_req", i),   64'(mem_req),   64'd1);
        chk($sformatf("v%0d_mem_addr", i),  mem_addr,       v.exp_maddr);
        chk($sformatf("v%0d_mem_we", i),    64'(mem_we),    64'(v.wr_en));
        chk($sformatf("v%0d_mem_wdata", i), mem_wdata,      v.exp_wdata);
        chk($sformatf("v%0d_mem_wmask", i), 64'(mem_wmask), 64'(v.exp_wmask));
        chk($sformatf("v%0d_req_nodone", i), 64'(valid_out), 64'd0);
    endtask

    task automatic run_vec(input int i, input vec_t v);
        int          cyc;
        logic [63:0] exp_res;
        chk($sformatf("v%0d_in_ready", i), 64'(in_ready), 64'd1);
        valid_in = 1'b1; addr_in = v.addr; wdata_in = v.wdata; MemOp_in = v.op;
        MemRd_in = v.rd_en; MemWr_in = v.wr_en; RegWr_in = v.regwr; rd_in = v.rd;
        exp_q.push_back(v.exp_result);
        step();
        valid_in = 1'b0;
        if (v.exp_req) begin
            for (int g = 0; g <= v.gnt_dly; g++) begin
                chk_req(i, v);
                if (g < v.gnt_dly) begin
                    // Junk upstream traffic while busy must not disturb the request.
                    valid_in = 1'b1; addr_in = {$urandom(), $urandom()};
                    wdata_in = {$urandom(), $urandom()}; MemOp_in = 3'($urandom_range(0, 7));
                    step();
                end
            end
            valid_in   = 1'b0;
            mem_gnt    = 1'b1;
            mem_rvalid = (v.rv_dly > 0);
            mem_rdata  = 64'hBAD0_BAD0_BAD0_BAD0;
            step();
            mem_gnt = 1'b0; mem_rvalid = 1'b0;
            for (int r = 0; r < v.rv_dly; r++) begin
                chk($sformatf("v%0d_wait_nodone", i), 64'(valid_out), 64'd0);
                chk($sformatf("v%0d_wait_noreq", i),  64'(mem_req),   64'd0);
                step();
            end
            mem_rvalid = 1'b1; mem_rdata = v.rdata; mem_err = v.err;
            step();
            mem_rvalid = 1'b0; mem_err = 1'b0; mem_rdata = '0;
        end else begin
            chk($sformatf("v%0d_no_req", i),  64'(mem_req),   64'd0);
            chk($sformatf("v%0d_latency", i), 64'(valid_out), 64'd1);
        end
        cyc = 0;
        while (!valid_out && cyc < 8) begin
            step();
            cyc++;
        end
        chk($sformatf("v%0d_done", i), 64'(valid_out), 64'd1);
        exp_res = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hx;
        chk($sformatf("v%0d_result", i), result,       exp_res);
        chk($sformatf("v%0d_error", i),  64'(error),   64'(v.exp_error));
        chk($sformatf("v%0d_regwr", i),  64'(RegWr),   64'(v.exp_regwr));
        chk($sformatf("v%0d_rd", i),     64'(rd),      64'(v.rd));
        block_out = (v.blk > 0);
        for (int b = 0; b < v.blk; b++) begin
            step();
            chk($sformatf("v%0d_held_valid", i),  64'(valid_out), 64'd1);
            chk($sformatf("v%0d_held_result", i), result,         exp_res);
        end
        block_out = 1'b0;
        step();
        chk($sformatf("v%0d_retired", i),  64'(valid_out), 64'd0);
        chk($sformatf("v%0d_ready_again", i), 64'(in_ready), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            addr                   wdata                  op    rd wr rw rd  rdata                  er g  r  b  req maddr                  exp_wdata              wmask  result                 err    rw
        vecs[0]  = '{64'h8000_0005, 64'h0000_0000_0000_00AB, 3'b000, 0, 1, 1, 5,  64'h0, 0, 0, 0, 0, 1, 64'h8000_0000, 64'hABAB_ABAB_ABAB_ABAB, 8'h20, 64'h0, 2'b00, 0};
        vecs[1]  = '{64'h8000_0002, 64'h0, 3'b001, 1, 0, 1, 10, 64'h0000_0000_8001_0000, 0, 1, 0, 0, 1, 64'h8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_8001, 2'b00, 1};
        vecs[2]  = '{64'h8000_0002, 64'h0, 3'b101, 1, 0, 1, 11, 64'h0000_0000_8001_0000, 0, 0, 1, 0, 1, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_0000_8001, 2'b00, 1};
        vecs[3]  = '{64'h8000_0006, 64'h0, 3'b010, 1, 0, 1, 7,  64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 2'b01, 0};
        vecs[4]  = '{64'h0000_1234, 64'h0, 3'b000, 0, 0, 1, 3,  64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 64'h0000_0000_0000_1234, 2'b00, 1};
        vecs[5]  = '{64'h8000_0006, 64'h1122_3344_5566_7788, 3'b001, 0, 1, 0, 0, 64'h0, 0, 1, 1, 0, 1, 64'h8000_0000, 64'h7788_7788_7788_7788, 8'hC0, 64'h0, 2'b00, 0};
        vecs[6]  = '{64'h8000_0004, 64'h1122_3344_5566_7788, 3'b010, 0, 1, 1, 9, 64'h0, 0, 2, 0, 1, 1, 64'h8000_0000, 64'h5566_7788_5566_7788, 8'hF0, 64'h0, 2'b00, 0};
        vecs[7]  = '{64'h8000_0008, 64'h0123_4567_89AB_CDEF, 3'b011, 0, 1, 0, 0, 64'h0, 0, 0, 0, 0, 1, 64'h8000_0008, 64'h0123_4567_89AB_CDEF, 8'hFF, 64'h0, 2'b00, 0};
        vecs[8]  = '{64'h8000_0007, 64'h0, 3'b000, 1, 0, 1, 12, 64'h8000_0000_0000_0000, 0, 0, 0, 0, 1, 64'h8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_FFFF_FF80, 2'b00, 1};
        vecs[9]  = '{64'h8000_0003, 64'h0, 3'b100, 1, 0, 1, 13, 64'h1122_3344_F566_7788, 0, 0, 0, 0, 1, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_0000_00F5, 2'b00, 1};
        vecs[10] = '{64'h8000_0004, 64'h0, 3'b010, 1, 0, 1, 14, 64'h8765_4321_0000_0000, 0, 0, 0, 0, 1, 64'h8000_0000, 64'h0, 8'h00, 64'hFFFF_FFFF_8765_4321, 2'b00, 1};
        vecs[11] = '{64'h8000_0000, 64'h0, 3'b110, 1, 0, 1, 15, 64'h0000_0000_FEDC_BA98, 0, 0, 0, 0, 1, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_FEDC_BA98, 2'b00, 1};
        vecs[12] = '{64'h8000_0010, 64'h0, 3'b011, 1, 0, 1, 16, 64'hDEAD_BEEF_CAFE_F00D, 0, 0, 0, 0, 1, 64'h8000_0010, 64'h0, 8'h00, 64'hDEAD_BEEF_CAFE_F00D, 2'b00, 1};
        vecs[13] = '{64'h8000_0018, 64'h0, 3'b011, 1, 0, 1, 17, 64'h0000_0000_0000_1111, 1, 0, 0, 0, 1, 64'h8000_0018, 64'h0, 8'h00, 64'h0, 2'b10, 0};
        vecs[14] = '{64'h8000_0100, 64'h0, 3'b010, 1, 0, 1, 18, 64'h0000_0000_1234_5678, 0, 3, 2, 2, 1, 64'h8000_0100, 64'h0, 8'h00, 64'h0000_0000_1234_5678, 2'b00, 1};
        vecs[15] = '{64'h8000_0001, 64'h55, 3'b001, 0, 1, 1, 19, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 2'b01, 0};
        vecs[16] = '{64'h8000_0004, 64'h0, 3'b011, 1, 0, 1, 20, 64'h0, 0, 0, 0, 0, 0, 64'h0, 64'h0, 8'h00, 64'h0, 2'b01, 0};
        vecs[17] = '{64'h8000_0006, 64'h0, 3'b001, 1, 0, 1, 22, 64'h7FFE_0000_0000_0000, 0, 0, 0, 0, 1, 64'h8000_0000, 64'h0, 8'h00, 64'h0000_0000_0000_7FFE, 2'b00, 1};

        rst = 1'b0; valid_in = 1'b0; addr_in = '0; wdata_in = '0; MemOp_in = '0;
        MemRd_in = 1'b0; MemWr_in = 1'b0; RegWr_in = 1'b0; rd_in = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_err = 1'b0; block_out = 1'b0;
        repeat (3) step();
        chk("reset_valid_out", 64'(valid_out), 64'd0);
        chk("reset_mem_req",   64'(mem_req),   64'd0);
        chk("reset_result",    result,         64'd0);
        chk("reset_error",     64'(error),     64'd0);
        chk("reset_regwr",     64'(RegWr),     64'd0);
        rst = 1'b1;
        step();
        chk("post_reset_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

        // Reset while waiting for the response, then a stray response afterwards.
        valid_in = 1'b1; addr_in = 64'h8000_0040; MemOp_in = 3'b011;
        MemRd_in = 1'b1; MemWr_in = 1'b0; RegWr_in = 1'b1; rd_in = 5'd21;
        step();
        valid_in = 1'b0;
        chk("abort_mem_req", 64'(mem_req), 64'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        chk("abort_in_wait", 64'(state_dbg), 64'(S_WAIT));
        rst = 1'b0;
        step();
        chk("abort_state",     64'(state_dbg), 64'(S_IDLE));
        chk("abort_valid_out", 64'(valid_out), 64'd0);
        chk("abort_mem_req0",  64'(mem_req),   64'd0);
        chk("abort_mem_we",    64'(mem_we),    64'd0);
        chk("abort_wmask",     64'(mem_wmask), 64'd0);
        chk("abort_result",    result,         64'd0);
        chk("abort_rd",        64'(rd),        64'd0);
        chk("abort_regwr",     64'(RegWr),     64'd0);
        chk("abort_error",     64'(error),     64'd0);
        rst = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 64'h5555_5555_5555_5555;
        step();
        mem_rvalid = 1'b0; mem_rdata = '0;
        chk("stray_in_ready", 64'(in_ready), 64'd1);
        for (int k = 0; k < 3; k++) begin
            chk("stray_no_retire", 64'(valid_out), 64'd0);
            step();
        end

        run_vec(100, vecs[4]);
        run_vec(101, vecs[12]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
